// File: rtl/pmi_fifo_prefetch_pkg.sv
// Shared definitions for the pmi_fifo prefetch adapter: read-latency decode and derived buffer depth.
package pmi_fifo_prefetch_pkg;

  localparam int unsigned LAT_NOREG = 1;
  localparam int unsigned LAT_REG   = 2;

  // Regmode strings are compared as fixed-width byte vectors, wide enough for "noreg".
  localparam int unsigned MODE_BITS = 40;

  function automatic int unsigned latencyOf(input logic [MODE_BITS-1:0] mode);
    return (mode == MODE_BITS'("noreg")) ? LAT_NOREG : LAT_REG;
  endfunction

  function automatic logic isKnownMode(input logic [MODE_BITS-1:0] mode);
    return (mode == MODE_BITS'("noreg")) || (mode == MODE_BITS'("reg"));
  endfunction

  // One slot per in-flight read plus one for the word currently presented.
  function automatic int unsigned depthOf(input int unsigned lat);
    return lat + 1;
  endfunction

endpackage

// File: rtl/pmi_fifo_prefetch_buf.sv
// Small register FIFO holding words returned by pmi_fifo until the consumer takes them.
module pmi_fifo_prefetch_buf #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 3
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       push,
  input  logic [width-1:0]           pushData,
  input  logic                       pop,
  output logic [width-1:0]           headData,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Push and pop on a full buffer share a slot: the head is read out before it is overwritten.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= pushData;
        tail      <= nextPtr(tail);
      end
      if (pop) head <= nextPtr(head);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign headData = mem[head];

endmodule

// File: rtl/pmi_fifo_prefetch.sv
// Turns the fixed-latency read port of pmi_fifo into a first-word-fall-through valid/ready stream.
module pmi_fifo_prefetch
  import pmi_fifo_prefetch_pkg::*;
#(
  parameter int unsigned pmi_data_width = 8,
  parameter              pmi_regmode    = "reg",
  parameter              pmi_family     = "EC"
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic [pmi_data_width-1:0] FifoQ,
  input  logic                      FifoEmpty,
  output logic                      FifoRdEn,
  output logic [pmi_data_width-1:0] DataOut,
  output logic                      Valid,
  input  logic                      Ready
);

  localparam int unsigned L   = latencyOf(MODE_BITS'(pmi_regmode));
  localparam int unsigned D   = depthOf(L);
  localparam int unsigned CBW = $clog2(D + 1);
  localparam int unsigned SW  = CBW + 1;

  if (!isKnownMode(MODE_BITS'(pmi_regmode)) || (MODE_BITS'(pmi_family) == '0)) begin : gBadParams
    $error("pmi_fifo_prefetch: pmi_regmode must be \"reg\" or \"noreg\" and pmi_family must be set");
  end

  logic [L-1:0]   inflight;
  logic [CBW-1:0] bufCount;
  logic           pop;
  logic           capture;
  logic [SW-1:0]  committed;
  logic [SW-1:0]  limit;

  assign pop     = Valid & Ready;
  assign capture = inflight[L-1];
  assign Valid   = (bufCount != '0);

  // Issue only if every word already owed to the buffer, plus this one, still has a slot.
  always_comb begin
    committed = SW'(bufCount) + SW'($countones(inflight));
    limit     = SW'(D) + SW'(pop);
    FifoRdEn  = ResetN & ~FifoEmpty & (committed < limit);
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) inflight <= '0;
    else         inflight <= (inflight << 1) | L'(FifoRdEn);
  end

  pmi_fifo_prefetch_buf #(
    .width(pmi_data_width),
    .depth(D)
  ) outBuf (
    .clk     (Clock),
    .resetN  (ResetN),
    .push    (capture),
    .pushData(FifoQ),
    .pop     (pop),
    .headData(DataOut),
    .count   (bufCount)
  );

endmodule

// File: tb/tb_pmi_fifo_prefetch.sv
// Directed bench for pmi_fifo_prefetch: one instance per latency, each fed by a behavioural pmi_fifo.
module tb_pmi_fifo_prefetch;
  import pmi_fifo_prefetch_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned LR = latencyOf(MODE_BITS'("reg"));
  localparam int unsigned DR = depthOf(LR);
  localparam int unsigned LN = latencyOf(MODE_BITS'("noreg"));
  localparam int unsigned DN = depthOf(LN);

  typedef struct {
    logic         ready;
    logic         expRd;
    logic         expValid;
    logic [W-1:0] expData;
    logic         chkData;
  } vec_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  logic [W-1:0] fifoQR = '0;
  logic         emptyR = 1'b1;
  logic         rdEnR;
  logic [W-1:0] dataR;
  logic         validR;
  logic         readyR = 1'b0;

  logic [W-1:0] fifoQN = '0;
  logic         emptyN = 1'b1;
  logic         rdEnN;
  logic [W-1:0] dataN;
  logic         validN;
  logic         readyN = 1'b0;

  logic [W-1:0] qR[$];
  logic [W-1:0] qN[$];
  logic [W-1:0] outR[$];
  logic [W-1:0] outN[$];
  logic [W-1:0] pipeR[LR];
  logic [W-1:0] pipeN[LN];
  logic [W-1:0] sent[64];
  vec_t         vecs[16];

  int checks = 0;
  int errors = 0;
  int violR = 0, violN = 0, ovfR = 0, ovfN = 0;
  int cnt;

  always #5 clk = ~clk;

  pmi_fifo_prefetch #(.pmi_data_width(W), .pmi_regmode("reg"), .pmi_family("EC")) dR (
    .Clock(clk), .ResetN(resetN), .FifoQ(fifoQR), .FifoEmpty(emptyR),
    .FifoRdEn(rdEnR), .DataOut(dataR), .Valid(validR), .Ready(readyR)
  );

  pmi_fifo_prefetch #(.pmi_data_width(W), .pmi_regmode("noreg"), .pmi_family("EC")) dN (
    .Clock(clk), .ResetN(resetN), .FifoQ(fifoQN), .FifoEmpty(emptyN),
    .FifoRdEn(rdEnN), .DataOut(dataN), .Valid(validN), .Ready(readyN)
  );

  // Upstream model for the "reg" instance: a read seen in cycle t shows on FifoQ in cycle t+LR.
  always begin
    logic rdSeen;
    @(negedge clk);
    rdSeen = rdEnR;
    if (rdEnR && emptyR) violR++;
    if (int'(dR.bufCount) == int'(DR) && dR.inflight[LR-1] && !(validR && readyR)) ovfR++;
    if (validR && readyR) outR.push_back(dataR);
    @(posedge clk);
    #2;
    for (int i = LR - 1; i > 0; i--) pipeR[i] = pipeR[i-1];
    pipeR[0] = (rdSeen && qR.size() > 0) ? qR.pop_front() : 8'hEE;
    fifoQR = pipeR[LR-1];
    emptyR = (qR.size() == 0);
  end

  always begin
    logic rdSeen;
    @(negedge clk);
    rdSeen = rdEnN;
    if (rdEnN && emptyN) violN++;
    if (int'(dN.bufCount) == int'(DN) && dN.inflight[LN-1] && !(validN && readyN)) ovfN++;
    if (validN && readyN) outN.push_back(dataN);
    @(posedge clk);
    #2;
    for (int i = LN - 1; i > 0; i--) pipeN[i] = pipeN[i-1];
    pipeN[0] = (rdSeen && qN.size() > 0) ? qN.pop_front() : 8'hEE;
    fifoQN = pipeN[LN-1];
    emptyN = (qN.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic rd, logic v, logic [W-1:0] d, logic c);
    vec_t x;
    x.ready = r; x.expRd = rd; x.expValid = v; x.expData = d; x.chkData = c;
    return x;
  endfunction

  // Entered and left at 1 time unit after a rising edge; one row per cycle on the "reg" instance.
  task automatic runTable(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      readyR = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d rdEn", i), 32'(rdEnR), 32'(vecs[i].expRd));
      check($sformatf("vec%0d valid", i), 32'(validR), 32'(vecs[i].expValid));
      if (vecs[i].chkData) check($sformatf("vec%0d data", i), 32'(dataR), 32'(vecs[i].expData));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 3 preloaded words, Ready high
    vecs[0]  = mk(1, 1, 0, 8'h00, 0);
    vecs[1]  = mk(1, 1, 0, 8'h00, 0);
    vecs[2]  = mk(1, 1, 0, 8'h00, 0);
    vecs[3]  = mk(1, 0, 1, 8'h11, 1);
    vecs[4]  = mk(1, 0, 1, 8'h22, 1);
    vecs[5]  = mk(1, 0, 1, 8'h33, 1);
    vecs[6]  = mk(1, 0, 0, 8'h00, 0);
    vecs[7]  = mk(0, 0, 0, 8'h00, 0);
    // single word 0xA5, consumer stalls two cycles before accepting
    vecs[8]  = mk(0, 1, 0, 8'h00, 0);
    vecs[9]  = mk(0, 0, 0, 8'h00, 0);
    vecs[10] = mk(0, 0, 0, 8'h00, 0);
    vecs[11] = mk(0, 0, 1, 8'hA5, 1);
    vecs[12] = mk(0, 0, 1, 8'hA5, 1);
    vecs[13] = mk(1, 0, 1, 8'hA5, 1);
    vecs[14] = mk(1, 0, 0, 8'h00, 0);
    vecs[15] = mk(0, 0, 0, 8'h00, 0);

    repeat (2) tick();
    qR.push_back(8'h11); qR.push_back(8'h22); qR.push_back(8'h33);
    @(negedge clk);
    check("reset rdEnR", 32'(rdEnR), 32'd0);
    check("reset validR", 32'(validR), 32'd0);
    check("reset dataR", 32'(dataR), 32'd0);
    check("reset validN", 32'(validN), 32'd0);
    check("reset dataN", 32'(dataN), 32'd0);
    tick();
    resetN = 1'b1;
    runTable(0, 7);

    // 10 words with the consumer stalled: buffer fills, then drains at one word per cycle
    readyR = 1'b0;
    for (int k = 0; k < 10; k++) qR.push_back(8'(8'h40 + k));
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rdEnR) cnt++;
      tick();
    end
    check("stall rdEn pulses", 32'(cnt), 32'd3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("stall valid c%0d", c), 32'(validR), 32'd1);
      check($sformatf("stall data c%0d", c), 32'(dataR), 32'h40);
      tick();
    end
    readyR = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("drain valid w%0d", k), 32'(validR), 32'd1);
      check($sformatf("drain data w%0d", k), 32'(dataR), 32'(8'h40 + k));
      tick();
    end
    @(negedge clk);
    check("drain done valid", 32'(validR), 32'd0);
    tick();
    readyR = 1'b0;
    repeat (2) tick();

    qR.push_back(8'hA5);
    runTable(8, 15);

    // reset while two reads are still on their way back
    outR.delete();
    readyR = 1'b0;
    qR.push_back(8'hE1); qR.push_back(8'hE2);
    @(negedge clk); check("flush rd0", 32'(rdEnR), 32'd1); tick();
    @(negedge clk); check("flush rd1", 32'(rdEnR), 32'd1); tick();
    resetN = 1'b0;
    @(negedge clk); check("flush rdEn in reset", 32'(rdEnR), 32'd0); tick();
    resetN = 1'b1;
    @(negedge clk);
    check("flush valid after reset", 32'(validR), 32'd0);
    check("flush data after reset", 32'(dataR), 32'd0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (validR) cnt++;
    end
    check("flush stale words seen", 32'(cnt), 32'd0);
    tick();
    qR.push_back(8'h5C);
    readyR = 1'b1;
    for (int c = 0; c < 12 && outR.size() == 0; c++) tick();
    repeat (3) tick();
    check("flush accepted count", 32'(outR.size()), 32'd1);
    check("flush first word", (outR.size() > 0) ? 32'(outR[0]) : 32'hFFFF_FFFF, 32'h5C);
    readyR = 1'b0;

    // 64 random words through the "noreg" instance with Ready toggling every cycle
    for (int k = 0; k < 64; k++) begin
      sent[k] = 8'($urandom_range(0, 255));
      qN.push_back(sent[k]);
    end
    readyN = 1'b1;
    for (int c = 0; c < 400 && outN.size() < 64; c++) begin
      tick();
      readyN = ~readyN;
    end
    readyN = 1'b0;
    repeat (4) tick();
    check("toggle word count", 32'(outN.size()), 32'd64);
    for (int k = 0; k < 64; k++)
      check($sformatf("toggle word %0d", k), (k < outN.size()) ? 32'(outN[k]) : 32'hFFFF_FFFF, 32'(sent[k]));

    check("rdEn while empty (reg)", 32'(violR), 32'd0);
    check("rdEn while empty (noreg)", 32'(violN), 32'd0);
    check("capture into full (reg)", 32'(ovfR), 32'd0);
    check("capture into full (noreg)", 32'(ovfN), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
